// File: rtl/iob_fp_round_pipe.sv
// FP round/normalise stage: IEEE-mode rounding, renormalise, saturate to inf; IOB_FP_ROUND_FLAGS_EN adds inexact/overflow flags.
// Latency 2 cycles, throughput 1 word/cycle.
// Backpressure: valid/ready elastic pipe; each stage advances only when the next stage is empty or draining.
module iob_fp_round_pipe #(
    parameter int DATA_W  = 24,
    parameter int EXP_W   = 8,
    parameter int GUARD_W = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [2:0]                rmode_i,
    input  logic                      sign_i,
    input  logic [EXP_W-1:0]          exponent_i,
    input  logic [DATA_W+GUARD_W-1:0] mantissa_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      sign_o,
    output logic [EXP_W-1:0]          exponent_o,
    output logic [DATA_W-2:0]         mantissa_o,
    output logic                      inexact_o,
    output logic                      overflow_o
);

    localparam int MW    = DATA_W + GUARD_W;
    localparam int LZC_W = $clog2(DATA_W + 1);
    localparam int EW    = EXP_W + 2;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [DATA_W:0]  m1;
    } s1_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [DATA_W-2:0] mant;
    } res_t;

    logic v1_q, v1_d, v2_q, v2_d;
    s1_t  s1_q, s1_d;
    res_t s2_q, s2_d;
    logic s1_en, s2_en;

    logic            lsb, g, s, inc;
    logic [DATA_W:0] m1_in;

    always_comb begin
        lsb = mantissa_i[GUARD_W];
        g   = mantissa_i[GUARD_W-1];
        s   = |mantissa_i[GUARD_W-2:0];
        case (rmode_i)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign_i & (g | s);
            3'b011:  inc = ~sign_i & (g | s);
            3'b100:  inc = g;
            default: inc = g & (s | lsb);
        endcase
        m1_in = {1'b0, mantissa_i[MW-1:GUARD_W]} + {{DATA_W{1'b0}}, inc};
    end

    logic [LZC_W-1:0]  lzc;
    logic [DATA_W-1:0] m_low, m_shift;
    logic [EW-1:0]     e_wide;
    logic [DATA_W-2:0] mant_n;
    logic              ovf_n;
    res_t              res_n;

    always_comb begin
        m_low = s1_q.m1[DATA_W-1:0];
        lzc   = LZC_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++) begin
            if (m_low[i]) lzc = LZC_W'(DATA_W - 1 - i);
        end
        m_shift = m_low << lzc;
        ovf_n   = 1'b0;
        if (s1_q.m1[DATA_W]) begin
            e_wide = {2'b00, s1_q.exp} + EW'(1);
            mant_n = '0;
        end else if (m_low == '0 || {2'b00, s1_q.exp} < EW'(lzc)) begin
            // zero result or exponent would go below zero: flush to zero
            e_wide = '0;
            mant_n = '0;
        end else begin
            e_wide = {2'b00, s1_q.exp} - EW'(lzc);
            mant_n = m_shift[DATA_W-2:0];
        end
        res_n.sign = s1_q.sign;
        if (e_wide >= {2'b00, {EXP_W{1'b1}}}) begin
            ovf_n      = 1'b1;
            res_n.exp  = '1;
            res_n.mant = '0;
        end else begin
            res_n.exp  = e_wide[EXP_W-1:0];
            res_n.mant = mant_n;
        end
    end

    always_comb begin
        s2_en      = ~v2_q | out_ready_i;
        s1_en      = ~v1_q | s2_en;
        in_ready_o = s1_en & ~rst_i;
        v1_d       = s1_en ? in_valid_i : v1_q;
        v2_d       = s2_en ? v1_q : v2_q;
        s1_d       = s1_q;
        if (s1_en & in_valid_i) begin
            s1_d.sign = sign_i;
            s1_d.exp  = exponent_i;
            s1_d.m1   = m1_in;
        end
        s2_d = s2_q;
        if (s2_en & v1_q) s2_d = res_n;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign out_valid_o = v2_q;
    assign sign_o      = s2_q.sign;
    assign exponent_o  = s2_q.exp;
    assign mantissa_o  = s2_q.mant;

`ifdef IOB_FP_ROUND_FLAGS_EN
    logic inx1_q, inx1_d, inx2_q, inx2_d, ovf2_q, ovf2_d;

    always_comb begin
        inx1_d = (s1_en & in_valid_i) ? (g | s) : inx1_q;
        inx2_d = (s2_en & v1_q) ? inx1_q : inx2_q;
        ovf2_d = (s2_en & v1_q) ? ovf_n : ovf2_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inx1_q <= 1'b0;
            inx2_q <= 1'b0;
            ovf2_q <= 1'b0;
        end else begin
            inx1_q <= inx1_d;
            inx2_q <= inx2_d;
            ovf2_q <= ovf2_d;
        end
    end

    assign inexact_o  = inx2_q;
    assign overflow_o = ovf2_q;
`else
    assign inexact_o  = 1'b0;
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_iob_fp_round_pipe.sv
// Bench for iob_fp_round_pipe: vector table through a scoreboard, plus backpressure and reset sequences.
module tb_iob_fp_round_pipe;

`ifdef IOB_FP_ROUND_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif
    localparam int NVEC = 20;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  rmode;
    logic        sign_in, sign_out, inexact, overflow;
    logic [7:0]  exp_in, exp_out;
    logic [26:0] mant_in;
    logic [22:0] mant_out;

    iob_fp_round_pipe #(.DATA_W(24), .EXP_W(8), .GUARD_W(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .rmode_i(rmode), .sign_i(sign_in), .exponent_i(exp_in), .mantissa_i(mant_in),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .sign_o(sign_out), .exponent_o(exp_out), .mantissa_o(mant_out),
        .inexact_o(inexact), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  rm;
        logic        sg;
        logic [7:0]  ei;
        logic [26:0] mi;
        logic [7:0]  eo;
        logic [22:0] mo;
        logic        inx;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic        sg;
        logic [7:0]  eo;
        logic [22:0] mo;
        logic        inx;
        logic        ovf;
        int          acc;
        int          id;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    bit   check_lat = 1'b0;
    bit   hold_pending = 1'b0;
    logic [33:0] held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] rm, input logic sg, input logic [7:0] ei,
                                input logic [23:0] hi, input logic [2:0] lo,
                                input logic [7:0] eo, input logic [22:0] mo,
                                input logic inx, input logic ovf);
        vec_t v;
        v.rm = rm; v.sg = sg; v.ei = ei; v.mi = {hi, lo};
        v.eo = eo; v.mo = mo; v.inx = inx; v.ovf = ovf;
        return v;
    endfunction

    // Output monitor: scoreboard pop, latency and hold-stable checks
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", {sign_out, exp_out, mant_out, inexact, overflow}, held);
            end
            hold_pending = out_valid & ~out_ready;
            held = {sign_out, exp_out, mant_out, inexact, overflow};
            if (out_valid && out_ready) begin
                chk("output_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("v%0d_sign", e.id), sign_out, e.sg);
                    chk($sformatf("v%0d_exp", e.id), exp_out, e.eo);
                    chk($sformatf("v%0d_mant", e.id), mant_out, e.mo);
                    chk($sformatf("v%0d_inexact", e.id), inexact, e.inx);
                    chk($sformatf("v%0d_overflow", e.id), overflow, e.ovf);
                    if (check_lat) chk($sformatf("v%0d_latency", e.id), cyc - e.acc, 2);
                end
            end
        end
    end

    task automatic drive(input int id);
        in_valid = 1'b1;
        rmode    = vecs[id].rm;
        sign_in  = vecs[id].sg;
        exp_in   = vecs[id].ei;
        mant_in  = vecs[id].mi;
    endtask

    task automatic push(input int id);
        exp_t e;
        e.sg  = vecs[id].sg;
        e.eo  = vecs[id].eo;
        e.mo  = vecs[id].mo;
        e.inx = vecs[id].inx & FLAGS;
        e.ovf = vecs[id].ovf & FLAGS;
        e.acc = cyc;
        e.id  = id;
        sb.push_back(e);
    endtask

    task automatic send(input int id);
        bit acc = 1'b0;
        @(posedge clk) #1;
        drive(id);
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            if (in_ready) begin
                push(id);
                acc = 1'b1;
            end else begin
                @(posedge clk) #1;
            end
        end
        chk($sformatf("v%0d_accepted", id), acc, 1);
    endtask

    task automatic idle();
        @(posedge clk) #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        vecs[0]  = mk(3'b000, 0, 127, 24'h800001, 3'b100, 127, 23'h000002, 1, 0);
        vecs[1]  = mk(3'b000, 0, 127, 24'h800000, 3'b100, 127, 23'h000000, 1, 0);
        vecs[2]  = mk(3'b000, 0, 127, 24'hFFFFFF, 3'b100, 128, 23'h000000, 1, 0);
        vecs[3]  = mk(3'b001, 0, 127, 24'hFFFFFF, 3'b100, 127, 23'h7FFFFF, 1, 0);
        vecs[4]  = mk(3'b011, 0, 127, 24'h800000, 3'b001, 127, 23'h000001, 1, 0);
        vecs[5]  = mk(3'b011, 1, 127, 24'h800000, 3'b001, 127, 23'h000000, 1, 0);
        vecs[6]  = mk(3'b010, 1, 127, 24'h800000, 3'b001, 127, 23'h000001, 1, 0);
        vecs[7]  = mk(3'b010, 0, 127, 24'h800000, 3'b001, 127, 23'h000000, 1, 0);
        vecs[8]  = mk(3'b000, 0, 127, 24'h600000, 3'b000, 126, 23'h400000, 0, 0);
        vecs[9]  = mk(3'b000, 0, 254, 24'hFFFFFF, 3'b100, 255, 23'h000000, 1, 1);
        vecs[10] = mk(3'b100, 1, 127, 24'h800000, 3'b100, 127, 23'h000001, 1, 0);
        vecs[11] = mk(3'b101, 0, 127, 24'h800001, 3'b100, 127, 23'h000002, 1, 0);
        vecs[12] = mk(3'b000, 0, 100, 24'h000000, 3'b000, 0,   23'h000000, 0, 0);
        vecs[13] = mk(3'b000, 1, 5,   24'h000001, 3'b000, 0,   23'h000000, 0, 0);
        vecs[14] = mk(3'b001, 0, 255, 24'h800000, 3'b000, 255, 23'h000000, 0, 1);
        vecs[15] = mk(3'b000, 0, 30,  24'h000003, 3'b000, 8,   23'h400000, 0, 0);
        vecs[16] = mk(3'b010, 0, 254, 24'hFFFFFF, 3'b111, 254, 23'h7FFFFF, 1, 0);
        vecs[17] = mk(3'b000, 0, 127, 24'h7FFFFF, 3'b100, 127, 23'h000000, 1, 0);
        vecs[18] = mk(3'b011, 0, 254, 24'hFFFFFF, 3'b001, 255, 23'h000000, 1, 1);
        vecs[19] = mk(3'b000, 0, 0,   24'h000002, 3'b010, 0,   23'h000000, 1, 0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        rmode = '0; sign_in = 1'b0; exp_in = '0; mant_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_outputs", {sign_out, exp_out, mant_out, inexact, overflow}, 0);
        @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Back-to-back table vectors, downstream always ready
        out_ready = 1'b1;
        check_lat = 1'b1;
        for (int i = 0; i < NVEC; i++) send(i);
        idle();
        drain();
        check_lat = 1'b0;

        // Backpressure: 4 back-to-back offers, only 2 fit while stalled
        begin
            int idx = 0;
            out_ready = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk) #1;
                drive(idx);
                @(negedge clk);
                if (in_ready) begin
                    push(idx);
                    idx++;
                end
            end
            chk("bp_accepted", idx, 2);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            @(posedge clk) #1;
            out_ready = 1'b1;
            for (int t = 0; t < 50 && idx < 4; t++) begin
                drive(idx);
                @(negedge clk);
                if (in_ready) begin
                    push(idx);
                    idx++;
                end
                @(posedge clk) #1;
            end
            chk("bp_all_accepted", idx, 4);
            in_valid = 1'b0;
            drain();
        end

        // Reset with two words in flight: nothing may emerge
        out_ready = 1'b0;
        send(5);
        send(6);
        idle();
        @(posedge clk) #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        sb.delete();
        @(posedge clk) #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        @(posedge clk) #1;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);

        // Pipe still works after the flush
        check_lat = 1'b1;
        send(8);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
